// File: rtl/uart_rx_fifo_if.sv
// Purpose : byte, pop and status bundle between the UART receive FIFO and its neighbours.
// Ports   : the receiver push path (i_din_*), the controller pop path (i_rden, o_dout_*),
//           control inputs (flush, threshold, timeout, overflow clear) and status/irq outputs.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TO_W       = 16
);
  logic [7:0]          i_din_8b;
  logic                i_din_valid;
  logic                i_rden;
  logic [7:0]          o_dout_8b;
  logic                o_dout_valid;
  logic                i_flush;
  logic [DEPTH_LOG2:0] i_thresh;
  logic [TO_W-1:0]     i_timeout;
  logic                i_clr_ovf;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_empty;
  logic                o_full;
  logic                o_overflow;
  logic                o_timeout;
  logic                o_irq;

  // Driver side: receiver/controller/testbench
  modport master (
    output i_din_8b, i_din_valid, i_rden, i_flush, i_thresh, i_timeout, i_clr_ovf,
    input  o_dout_8b, o_dout_valid, o_count, o_empty, o_full, o_overflow, o_timeout, o_irq
  );

  // FIFO side
  modport slave (
    input  i_din_8b, i_din_valid, i_rden, i_flush, i_thresh, i_timeout, i_clr_ovf,
    output o_dout_8b, o_dout_valid, o_count, o_empty, o_full, o_overflow, o_timeout, o_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose : receive byte FIFO between UART receiver and controller, with threshold,
//           idle-timeout and sticky-overflow level interrupt.
// Latency : push visible in o_count after its edge; pop data registered, one edge after i_rden.
// Backpressure: none; pushes into a full FIFO are dropped (sticky overflow), pops on empty
//           return 8'h00 with valid so the read bus never stalls.
// Ports   : i_clk, i_rst_n (async active-low) plus the uart_rx_fifo_if slave modport.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TO_W       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_rx_fifo_if.slave bus
);

  localparam int                  DEPTH  = 1 << DEPTH_LOG2;
  localparam int                  CNT_W  = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [7:0]            mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [7:0]            dout_q;
  logic                  dout_vld_q;
  logic                  ovf_q;
  logic                  to_flag_q;
  logic [TO_W-1:0]       timer_q;

  // ------------------------------------------------------------------
  // Accept decisions
  // ------------------------------------------------------------------
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  logic [CNT_W-1:0] count_next;
  logic [TO_W-1:0]  timer_next;
  logic             to_next;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Flush overrides both sides; a pop on empty is answered but changes nothing.
  assign pop_ok  = bus.i_rden && !empty && !bus.i_flush;
  // A full FIFO can still take a byte when the same cycle frees a slot.
  assign push_ok = bus.i_din_valid && !bus.i_flush && (!full || pop_ok);
  assign drop    = bus.i_din_valid && !bus.i_flush && full && !pop_ok;

  always_comb begin
    count_next = count_q;
    if (bus.i_flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Idle timer: any traffic, a flush or an empty FIFO restarts it; otherwise it
  // counts idle cycles and parks at all-ones rather than wrapping.
  always_comb begin
    timer_next = timer_q;
    if (push_ok || pop_ok || bus.i_flush || empty) begin
      timer_next = '0;
    end else if (timer_q != '1) begin
      timer_next = timer_q + 1'b1;
    end
  end

  // The flag is raised on the edge where the timer reaches the programmed value,
  // so it appears exactly i_timeout idle cycles after the last push/pop.
  always_comb begin
    to_next = to_flag_q;
    if (pop_ok || bus.i_flush || (count_next == '0)) begin
      to_next = 1'b0;
    end else if ((bus.i_timeout != '0) && (timer_next == bus.i_timeout)) begin
      to_next = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Storage array: contents are don't-care after reset, so no reset here.
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wptr_q] <= bus.i_din_8b;
    end
  end

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= 8'h00;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      to_flag_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      count_q    <= count_next;
      timer_q    <= timer_next;
      to_flag_q  <= to_next;
      dout_vld_q <= bus.i_rden;

      if (bus.i_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + 1'b1;
        if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      end

      // Every pop request is answered; only a real pop carries data.
      // Read of mem sees the pre-edge contents, so a same-cycle push into the
      // slot being read cannot corrupt the returned byte.
      if (bus.i_rden) begin
        dout_q <= pop_ok ? mem[rptr_q] : 8'h00;
      end

      // Set wins over clear in the same cycle.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.i_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.o_dout_8b    = dout_q;
  assign bus.o_dout_valid = dout_vld_q;
  assign bus.o_count      = count_q;
  assign bus.o_empty      = empty;
  assign bus.o_full       = full;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_timeout    = to_flag_q;

  // Threshold term follows i_thresh immediately; zero disables it.
  assign bus.o_irq = ((bus.i_thresh != '0) && (count_q >= bus.i_thresh))
                     || to_flag_q || ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : self-checking bench for uart_rx_fifo: directed scenarios then random traffic
//           against a queue-based reference model.
// Ports   : none; drives the DUT through a uart_rx_fifo_if instance.
module tb_uart_rx_fifo;

  localparam int DL       = 4;
  localparam int TW       = 16;
  localparam int DEPTH    = 1 << DL;
  localparam int IDLE_MAX = (1 << TW) - 1;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL), .TO_W(TW)) ifc ();

  uart_rx_fifo #(.DEPTH_LOG2(DL), .TO_W(TW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Reference model: a byte queue plus the three flags
  // ------------------------------------------------------------------
  logic [7:0] q [$];
  bit         m_ovf;
  bit         m_to;
  int         m_idle;
  bit         m_vld;
  logic [7:0] m_dout;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_to   = 0;
    m_idle = 0;
    m_vld  = 0;
    m_dout = 8'h00;
  endtask

  task automatic model_step(input logic dv, input logic [7:0] d, input logic rd,
                            input logic fl, input logic clr);
    int sz0;
    bit pop;
    bit push;
    bit drop;
    sz0  = q.size();
    drop = 0;
    m_vld = rd;
    if (fl) begin
      m_dout = 8'h00;
      q.delete();
      m_to   = 0;
      m_idle = 0;
    end else begin
      pop    = rd && (sz0 > 0);
      push   = dv && ((sz0 < DEPTH) || pop);
      drop   = dv && !push;
      m_dout = pop ? q[0] : 8'h00;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      if (push || pop || sz0 == 0) m_idle = 0;
      else if (m_idle < IDLE_MAX)  m_idle++;
      if (pop || q.size() == 0) m_to = 0;
      else if (ifc.i_timeout != '0 && m_idle == int'(ifc.i_timeout)) m_to = 1;
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic compare_all();
    bit m_irq;
    m_irq = ((ifc.i_thresh != '0) && (q.size() >= int'(ifc.i_thresh))) || m_to || m_ovf;
    chk("count",      32'(ifc.o_count),      32'(q.size()));
    chk("empty",      32'(ifc.o_empty),      32'(q.size() == 0));
    chk("full",       32'(ifc.o_full),       32'(q.size() == DEPTH));
    chk("overflow",   32'(ifc.o_overflow),   32'(m_ovf));
    chk("timeout",    32'(ifc.o_timeout),    32'(m_to));
    chk("irq",        32'(ifc.o_irq),        32'(m_irq));
    chk("dout_valid", 32'(ifc.o_dout_valid), 32'(m_vld));
    if (m_vld) chk("dout", 32'(ifc.o_dout_8b), 32'(m_dout));
  endtask

  // One clock: apply inputs, step model at the edge, compare 1 time unit later.
  task automatic cyc(input logic dv, input logic [7:0] d, input logic rd,
                     input logic fl, input logic clr);
    ifc.i_din_valid = dv;
    ifc.i_din_8b    = d;
    ifc.i_rden      = rd;
    ifc.i_flush     = fl;
    ifc.i_clr_ovf   = clr;
    @(posedge clk);
    model_step(dv, d, rd, fl, clr);
    #1;
    compare_all();
  endtask

  task automatic push(input logic [7:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                     cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle();                    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    ifc.i_din_valid  = 1'b0;
    ifc.i_din_8b     = 8'h00;
    ifc.i_rden       = 1'b0;
    ifc.i_flush      = 1'b0;
    ifc.i_clr_ovf    = 1'b0;
    ifc.i_thresh     = '0;
    ifc.i_timeout    = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_dout", 32'(ifc.o_dout_8b), 32'h0);
    rst_n = 1'b1;

    // Basic ordering: 11,22,33 in and out
    push(8'h11); push(8'h22); push(8'h33);
    chk("cnt3", 32'(ifc.o_count), 32'd3);
    pop(); chk("pop_11", 32'(ifc.o_dout_8b), 32'h11);
    pop(); chk("pop_22", 32'(ifc.o_dout_8b), 32'h22);
    pop(); chk("pop_33", 32'(ifc.o_dout_8b), 32'h33);
    chk("empty_after", 32'(ifc.o_empty), 32'd1);

    // Overflow: 17 pushes, 0x10 dropped
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) chk("full_at_16", 32'(ifc.o_full), 32'd1);
    end
    chk("ovf_set", 32'(ifc.o_overflow), 32'd1);
    chk("ovf_irq", 32'(ifc.o_irq), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("ovf_pop", 32'(ifc.o_dout_8b), 32'(i));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ifc.o_overflow), 32'd0);

    // Full with simultaneous push+pop: no overflow, wrap-around ordering
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("pp_dout",  32'(ifc.o_dout_8b),  32'h40);
    chk("pp_count", 32'(ifc.o_count),    32'd16);
    chk("pp_ovf",   32'(ifc.o_overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop();
    chk("pp_last", 32'(ifc.o_dout_8b), 32'hAA);

    // Threshold interrupt
    ifc.i_thresh = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    chk("th_below", 32'(ifc.o_irq), 32'd0);
    push(8'h04);
    chk("th_at", 32'(ifc.o_irq), 32'd1);
    pop();
    chk("th_pop", 32'(ifc.o_irq), 32'd0);
    repeat (3) pop();
    ifc.i_thresh = '0;

    // Idle timeout
    ifc.i_timeout = 16'd10;
    push(8'h5A);
    repeat (9) idle();
    chk("to_early", 32'(ifc.o_timeout), 32'd0);
    idle();
    chk("to_fire", 32'(ifc.o_timeout), 32'd1);
    chk("to_irq",  32'(ifc.o_irq),     32'd1);
    pop();
    chk("to_clr",  32'(ifc.o_timeout), 32'd0);
    chk("to_irq0", 32'(ifc.o_irq),     32'd0);
    chk("to_dout", 32'(ifc.o_dout_8b), 32'h5A);
    ifc.i_timeout = '0;

    // Flush overrides push and pop
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("fl_count", 32'(ifc.o_count),      32'd0);
    chk("fl_vld",   32'(ifc.o_dout_valid), 32'd1);
    chk("fl_dout",  32'(ifc.o_dout_8b),    32'h00);

    // Asynchronous reset mid-stream
    push(8'hC1); push(8'hC2); push(8'hC3);
    ifc.i_din_valid = 1'b0;
    ifc.i_rden      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_dout", 32'(ifc.o_dout_8b), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        ifc.i_thresh  = 5'($urandom_range(0, 16));
        ifc.i_timeout = 16'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 99) < 3) begin
        for (int k = 0; k < 25; k++) idle();
      end else begin
        cyc(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2),
            1'($urandom_range(0, 99) < 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
